key_encoder: RTL and testbench

- Registered 8-key priority encoder with debounce and a valid/ready output handshake.
- It is the encode-side counterpart of the team's 3-to-8 one-hot decoder and uses the same bit mapping: key bit i ↔ code 7−i, so keys[7] encodes to 3'b000 and keys[0] to 3'b111.
- It sits between the board push-buttons and downstream logic, and delivers exactly one code per debounced press.

---
 rtl/key_encoder_pkg.sv | 29 ++
 rtl/key_sync.sv | 27 ++
 rtl/key_encoder.sv | 111 +++++++++++
 tb/tb_key_encoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/key_encoder_pkg.sv
// Shared types and the 8-to-3 priority mapping for key_encoder.
// Key bit i maps to code 7-i, mirroring the team's 3-to-8 one-hot decoder.
package key_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    EMIT         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  // Returns {multi, code}: the highest set bit wins and multi flags more than one set bit.
  function automatic logic [3:0] enc8to3(input logic [7:0] k);
    logic [2:0] c;
    logic [3:0] n;
    c = 3'd0;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) begin
        c = 3'(7 - i);
        n = n + 4'd1;
      end else begin
        n = n;
      end
    end
    return {(n > 4'd1), c};
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer, one chain per bit, cleared by the asynchronous reset.
module key_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability-settling chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
    end
  end

  assign dout = sync_r;

endmodule

// File: rtl/key_encoder.sv
// Debounced 8-key priority encoder that offers one code per press over a
// valid/ready handshake and demands a full quiet window before the next press.
module key_encoder
  import key_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] keys,
  output logic [2:0] code,
  output logic       multi,
  output logic       valid,
  input  logic       ready,
  output logic       idle
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [7:0]       ks_s;
  logic [7:0]       snap_r;
  logic [CNT_W-1:0] cnt_r;
  state_t           state_r;
  logic [2:0]       code_r;
  logic             multi_r;
  logic             valid_r;
  logic             idle_r;

  key_sync #(.WIDTH(8)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (keys),
    .dout (ks_s)
  );

  // Press/debounce/emit/release sequencing with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      snap_r  <= 8'h00;
      cnt_r   <= CNT_ZERO;
      code_r  <= 3'd0;
      multi_r <= 1'b0;
      valid_r <= 1'b0;
      idle_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (ks_s != 8'h00) begin
            snap_r  <= ks_s;
            cnt_r   <= CNT_ZERO;
            state_r <= DEBOUNCE;
            idle_r  <= 1'b0;
          end else begin
            idle_r  <= 1'b1;
          end
        end
        DEBOUNCE: begin
          // A changed snapshot outranks the terminal count so any bounce restarts the window.
          if (ks_s == 8'h00) begin
            state_r <= IDLE;
            idle_r  <= 1'b1;
          end else if (ks_s != snap_r) begin
            snap_r <= ks_s;
            cnt_r  <= CNT_ZERO;
          end else if (cnt_r == CNT_TERM) begin
            {multi_r, code_r} <= enc8to3(snap_r);
            valid_r <= 1'b1;
            state_r <= EMIT;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        EMIT: begin
          if (ready) begin
            valid_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
            state_r <= WAIT_RELEASE;
          end else begin
            valid_r <= 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (ks_s != 8'h00) begin
            cnt_r <= CNT_ZERO;
          end else if (cnt_r == CNT_TERM) begin
            state_r <= IDLE;
            idle_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
          valid_r <= 1'b0;
          idle_r  <= 1'b1;
        end
      endcase
    end
  end

  assign code  = code_r;
  assign multi = multi_r;
  assign valid = valid_r;
  assign idle  = idle_r;

endmodule

// File: tb/tb_key_encoder.sv
// Directed bench for key_encoder with DEBOUNCE_CYCLES = 4; inputs change on
// the falling edge and outputs are sampled on the falling edge.
module tb_key_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] keys;
  logic       ready;
  logic [2:0] code;
  logic       multi;
  logic       valid;
  logic       idle;

  int checks = 0;
  int errors = 0;
  int pulses;
  logic [2:0] pcode;

  key_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .keys (keys),
    .code (code),
    .multi(multi),
    .valid(valid),
    .ready(ready),
    .idle (idle)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic watch(input int n, output int cnt, output logic [2:0] last);
    cnt  = 0;
    last = 3'd0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (valid) begin
        cnt++;
        last = code;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    keys  = 8'h00;
    ready = 1'b0;
    step(3);
    rst_n = 1'b1;

    // Quiet after reset
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!idle || valid || (code != 3'd0)) pulses++;
    end
    check_eq("rst_idle_quiet", 8'(pulses), 8'd0);
    check_eq("rst_outs", {3'd0, idle, valid, code}, 8'b0001_0000);

    // Single key, ready held high: one pulse after edge 6
    keys  = 8'h04;
    ready = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 6) check_eq("s2_pre_valid", {7'd0, valid}, 8'd0);
      if (i == 7) begin
        check_eq("s2_valid", {7'd0, valid}, 8'd1);
        check_eq("s2_code", {5'd0, code}, 8'd5);
        check_eq("s2_multi", {7'd0, multi}, 8'd0);
      end
      if (valid) pulses++;
    end
    check_eq("s2_pulses", 8'(pulses), 8'd1);
    keys = 8'h00;
    step(5);
    check_eq("s2_release_early", {7'd0, idle}, 8'd0);
    step(1);
    check_eq("s2_release_idle", {7'd0, idle}, 8'd1);

    // Two keys, ready low: code frozen until accepted
    keys  = 8'h82;
    ready = 1'b0;
    step(7);
    check_eq("s3_valid", {7'd0, valid}, 8'd1);
    check_eq("s3_code", {5'd0, code}, 8'd0);
    check_eq("s3_multi", {7'd0, multi}, 8'd1);
    keys = 8'h01;
    step(5);
    check_eq("s3_hold_valid", {7'd0, valid}, 8'd1);
    check_eq("s3_hold_code", {5'd0, code}, 8'd0);
    check_eq("s3_hold_multi", {7'd0, multi}, 8'd1);
    ready = 1'b1;
    step(1);
    check_eq("s3_accept_drop", {7'd0, valid}, 8'd0);
    keys = 8'h00;
    step(8);
    check_eq("s3_idle", {7'd0, idle}, 8'd1);

    // Bounce then steady hold
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? 8'h10 : 8'h00;
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        if (valid) pulses++;
      end
    end
    check_eq("s4_bounce_quiet", 8'(pulses), 8'd0);
    keys = 8'h10;
    step(6);
    check_eq("s4_pre_valid", {7'd0, valid}, 8'd0);
    step(1);
    check_eq("s4_valid", {7'd0, valid}, 8'd1);
    check_eq("s4_code", {5'd0, code}, 8'd3);
    step(1);
    check_eq("s4_pulse_end", {7'd0, valid}, 8'd0);
    keys = 8'h00;
    step(8);
    check_eq("s4_idle", {7'd0, idle}, 8'd1);

    // Short release does not re-arm; a full quiet window does
    keys = 8'h40;
    watch(10, pulses, pcode);
    check_eq("s5_first_pulses", 8'(pulses), 8'd1);
    check_eq("s5_first_code", {5'd0, pcode}, 8'd1);
    keys = 8'h00;
    step(2);
    keys = 8'h40;
    watch(12, pulses, pcode);
    check_eq("s5_short_release", 8'(pulses), 8'd0);
    keys = 8'h00;
    step(8);
    check_eq("s5_idle", {7'd0, idle}, 8'd1);
    keys = 8'h40;
    watch(10, pulses, pcode);
    check_eq("s5_second_pulses", 8'(pulses), 8'd1);
    check_eq("s5_second_code", {5'd0, pcode}, 8'd1);
    keys = 8'h00;
    step(8);

    // Asynchronous reset in the middle of EMIT
    keys  = 8'h20;
    ready = 1'b0;
    step(8);
    check_eq("s6_emit_valid", {7'd0, valid}, 8'd1);
    check_eq("s6_emit_code", {5'd0, code}, 8'd2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("s6_rst_outs", {3'd0, idle, valid, multi, code[1:0]}, 8'b0001_0000);
    check_eq("s6_rst_code", {5'd0, code}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(6);
    check_eq("s6_relatch_pre", {7'd0, valid}, 8'd0);
    step(1);
    check_eq("s6_relatch_valid", {7'd0, valid}, 8'd1);
    check_eq("s6_relatch_code", {5'd0, code}, 8'd2);
    ready = 1'b1;
    step(1);
    check_eq("s6_accept", {7'd0, valid}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
